// File: rtl/result_buf_writer.sv
// Packs classifier results into buffer words and writes them out, one word per WRITE cycle.
// A run is armed by start_i and closed by a one-cycle buf_wr_done pulse after the last word.
module result_buf_writer #(
   parameter int IN_IMG_NUM = 10,
   parameter int RES_W      = 4,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              res_valid_i,
   input  logic [RES_W-1:0]  res_data_i,
   output logic              res_ready_o,
   output logic              buf_we_o,
   output logic [ADDR_W-1:0] buf_addr_o,
   output logic [WORD_W-1:0] buf_wdata_o,
   output logic              buf_wr_done,
   output logic              busy_o,
   output logic [15:0]       img_cnt_o
);

   localparam int LANES  = WORD_W / RES_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
   localparam logic [15:0]       IMG_LAST  = 16'(IN_IMG_NUM);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t              state_reg;
   logic [LANE_W-1:0]   lane_reg;
   logic [15:0]         img_cnt_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [WORD_W-1:0]   pack_reg;
   logic [WORD_W-1:0]   pack_next;
   logic [15:0]         img_cnt_next;
   logic                ready_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_out_reg;
   logic [WORD_W-1:0]   wdata_reg;
   logic                done_reg;
   logic                handshake;
   logic                word_full;

   // Only the lane addressed by lane_reg takes the incoming result; the rest keep their value.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(gi);
         assign pack_next[gi*RES_W +: RES_W] =
            (lane_reg == LANE_IDX) ? res_data_i : pack_reg[gi*RES_W +: RES_W];
      end
   endgenerate

   assign handshake    = ready_reg & res_valid_i;
   assign img_cnt_next = img_cnt_reg + 16'd1;
   assign word_full    = (lane_reg == LANE_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         lane_reg     <= '0;
         img_cnt_reg  <= '0;
         addr_reg     <= '0;
         pack_reg     <= '0;
         ready_reg    <= 1'b0;
         we_reg       <= 1'b0;
         addr_out_reg <= '0;
         wdata_reg    <= '0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  img_cnt_reg <= '0;
                  addr_reg    <= '0;
                  pack_reg    <= '0;
                  lane_reg    <= '0;
                  ready_reg   <= 1'b1;
                  state_reg   <= COLLECT;
               end
            end
            COLLECT: begin
               if (handshake) begin
                  pack_reg    <= pack_next;
                  img_cnt_reg <= img_cnt_next;
                  lane_reg    <= word_full ? '0 : lane_reg + LANE_W'(1);
                  // Word output is loaded with pack_next so the last lane lands in this write.
                  if (word_full || (img_cnt_next == IMG_LAST)) begin
                     ready_reg    <= 1'b0;
                     we_reg       <= 1'b1;
                     addr_out_reg <= addr_reg;
                     wdata_reg    <= pack_next;
                     state_reg    <= WRITE;
                  end
               end
            end
            WRITE: begin
               we_reg       <= 1'b0;
               addr_out_reg <= '0;
               wdata_reg    <= '0;
               if (img_cnt_reg == IMG_LAST) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  addr_reg  <= addr_reg + ADDR_W'(1);
                  pack_reg  <= '0;
                  lane_reg  <= '0;
                  ready_reg <= 1'b1;
                  state_reg <= COLLECT;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign res_ready_o = ready_reg;
   assign buf_we_o    = we_reg;
   assign buf_addr_o  = addr_out_reg;
   assign buf_wdata_o = wdata_reg;
   assign buf_wr_done = done_reg;
   assign busy_o      = (state_reg != IDLE);
   assign img_cnt_o   = img_cnt_reg;

endmodule

// File: tb/tb_result_buf_writer.sv
// Bench for result_buf_writer: cycle tables for idle/back-to-back/IN_IMG_NUM=8 runs,
// plus hand-written sequences for gapped input, ignored start pulses and async reset.
module tb_result_buf_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0, res_valid = 1'b0;
   logic [3:0]  res_data = 4'd0;
   logic        res_ready, buf_we, buf_wr_done, busy;
   logic [7:0]  buf_addr;
   logic [31:0] buf_wdata;
   logic [15:0] img_cnt;

   logic        start8 = 1'b0, valid8 = 1'b0;
   logic [3:0]  data8 = 4'd0;
   logic        ready8, we8, done8, busy8;
   logic [7:0]  addr8;
   logic [31:0] wdata8;
   logic [15:0] cnt8;

   result_buf_writer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .res_valid_i(res_valid), .res_data_i(res_data),
      .res_ready_o(res_ready), .buf_we_o(buf_we), .buf_addr_o(buf_addr), .buf_wdata_o(buf_wdata),
      .buf_wr_done(buf_wr_done), .busy_o(busy), .img_cnt_o(img_cnt)
   );

   result_buf_writer #(.IN_IMG_NUM(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start8), .res_valid_i(valid8), .res_data_i(data8),
      .res_ready_o(ready8), .buf_we_o(we8), .buf_addr_o(addr8), .buf_wdata_o(wdata8),
      .buf_wr_done(done8), .busy_o(busy8), .img_cnt_o(cnt8)
   );

   typedef struct {
      logic        start;
      logic        valid;
      logic [3:0]  data;
      logic        ready;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        done;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          done_cnt = 0;
   int          hs_edge = 0;
   int          we_cyc = 0;
   int          done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Cycle numbering: the period after edge k is cycle k+1.
   always begin
      @(negedge clk);
      #1;
      if (buf_we) begin
         wr_addr_q.push_back(int'(buf_addr));
         wr_data_q.push_back(buf_wdata);
         we_cyc = cyc + 1;
      end
      if (buf_wr_done) begin
         done_cnt++;
         done_cyc = cyc + 1;
      end
      if (res_valid && res_ready) hs_edge = cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic va, input logic [3:0] d,
                               input logic rd, input logic we, input logic [7:0] a,
                               input logic [31:0] wd, input logic dn, input logic bz,
                               input logic [15:0] c);
      vec_t v;
      v.start = st; v.valid = va; v.data = d; v.ready = rd; v.we = we;
      v.addr = a; v.wdata = wd; v.done = dn; v.busy = bz; v.cnt = c;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag, input bit b8);
      logic r, w, dn, bz;
      logic [7:0] a;
      logic [31:0] wd;
      logic [15:0] c;
      if (b8) begin
         start8 = v.start; valid8 = v.valid; data8 = v.data;
      end else begin
         start = v.start; res_valid = v.valid; res_data = v.data;
      end
      @(posedge clk);
      @(negedge clk);
      if (b8) begin
         r = ready8; w = we8; a = addr8; wd = wdata8; dn = done8; bz = busy8; c = cnt8;
      end else begin
         r = res_ready; w = buf_we; a = buf_addr; wd = buf_wdata; dn = buf_wr_done; bz = busy; c = img_cnt;
      end
      chk({tag, " ready"}, 32'(r), 32'(v.ready));
      chk({tag, " we"},    32'(w), 32'(v.we));
      chk({tag, " addr"},  32'(a), 32'(v.addr));
      chk({tag, " wdata"}, wd, v.wdata);
      chk({tag, " done"},  32'(dn), 32'(v.done));
      chk({tag, " busy"},  32'(bz), 32'(v.busy));
      chk({tag, " cnt"},   32'(c), 32'(v.cnt));
      $display("%s: ready=%0b we=%0b addr=%0d wdata=%h done=%0b busy=%0b cnt=%0d",
               tag, r, w, a, wd, dn, bz, c);
   endtask

   task automatic send(input logic [3:0] d, input int gap);
      int n;
      res_valid = 1'b0;
      repeat (gap) @(negedge clk);
      res_valid = 1'b1;
      res_data  = d;
      n = 0;
      while (!res_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send ready", 32'(res_ready), 32'd1);
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt = 0;
      hs_edge  = 0;
      we_cyc   = 0;
      done_cyc = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_ref(input int gapmax);
      pulse_start();
      for (int i = 0; i < 10; i++)
         send(4'((i + 1) % 10), (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
   endtask

   task automatic check_run(input string tag);
      chk({tag, " nwrites"}, 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() >= 2) begin
         chk({tag, " addr0"}, 32'(wr_addr_q[0]), 32'd0);
         chk({tag, " data0"}, wr_data_q[0], 32'h8765_4321);
         chk({tag, " addr1"}, 32'(wr_addr_q[1]), 32'd1);
         chk({tag, " data1"}, wr_data_q[1], 32'h0000_0009);
      end
      chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, " img_cnt"}, 32'(img_cnt), 32'd10);
      $display("%s: writes=%0d done_pulses=%0d img_cnt=%0d", tag, wr_addr_q.size(), done_cnt, img_cnt);
   endtask

   initial begin
      int seq8[8];
      seq8 = '{3, 1, 4, 1, 5, 9, 2, 6};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst ready", 32'(res_ready), 32'd0);
      chk("rst we",    32'(buf_we), 32'd0);
      chk("rst wdata", buf_wdata, 32'd0);
      chk("rst done",  32'(buf_wr_done), 32'd0);
      chk("rst busy",  32'(busy), 32'd0);
      chk("rst cnt",   32'(img_cnt), 32'd0);
      rst = 1'b0;

      // Idle with valid held high and no start
      tbl.delete();
      for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 1, 4'd5, 0, 0, 0, 0, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], $sformatf("t1 v%0d", i), 1'b0);

      // Back-to-back run 1..9,0
      tbl.delete();
      tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 0, 0, 1, 0));
      for (int k = 1; k <= 7; k++) tbl.push_back(mk(0, 1, 4'(k), 1, 0, 0, 0, 0, 1, 16'(k)));
      tbl.push_back(mk(0, 1, 4'd8, 0, 1, 0, 32'h8765_4321, 0, 1, 8));
      tbl.push_back(mk(0, 1, 4'd9, 1, 0, 0, 0, 0, 1, 8));
      tbl.push_back(mk(0, 1, 4'd9, 1, 0, 0, 0, 0, 1, 9));
      tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 32'h0000_0009, 0, 1, 10));
      tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 1, 1, 10));
      tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 10));
      foreach (tbl[i]) apply(tbl[i], $sformatf("t2 v%0d", i), 1'b0);

      // Random valid gaps, latency of write and done relative to last handshake
      clear_mon();
      run_ref(3);
      repeat (4) @(negedge clk);
      check_run("t3");
      chk("t3 we latency", 32'(we_cyc - hs_edge), 32'd1);
      chk("t3 done latency", 32'(done_cyc - hs_edge), 32'd2);

      // start_i during COLLECT and during DONE is ignored
      clear_mon();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) pulse_start();
         send(4'((i + 1) % 10), 0);
      end
      chk("t4 we", 32'(buf_we), 32'd1);
      @(negedge clk);
      chk("t4 done", 32'(buf_wr_done), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4 busy after done", 32'(busy), 32'd0);
      chk("t4 no 2nd done", 32'(buf_wr_done), 32'd0);
      repeat (3) @(negedge clk);
      chk("t4 still idle", 32'(busy), 32'd0);
      check_run("t4");

      // Async reset mid-run, then a clean run
      clear_mon();
      pulse_start();
      for (int i = 0; i < 5; i++) send(4'(i + 1), 0);
      chk("t5 cnt before rst", 32'(img_cnt), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("t5 async ready", 32'(res_ready), 32'd0);
      chk("t5 async busy",  32'(busy), 32'd0);
      chk("t5 async cnt",   32'(img_cnt), 32'd0);
      chk("t5 async we",    32'(buf_we), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5 no done", 32'(done_cnt), 32'd0);
      chk("t5 no write", 32'(wr_addr_q.size()), 32'd0);
      clear_mon();
      run_ref(0);
      repeat (4) @(negedge clk);
      check_run("t5");

      // IN_IMG_NUM=8: single full word, then done
      tbl.delete();
      tbl.push_back(mk(1, 0, 4'd0, 1, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 1, 4'(seq8[k]), 1, 0, 0, 0, 0, 1, 16'(k + 1)));
      tbl.push_back(mk(0, 1, 4'(seq8[7]), 0, 1, 0, 32'h6295_1413, 0, 1, 8));
      tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 1, 1, 8));
      tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 8));
      tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 8));
      foreach (tbl[i]) apply(tbl[i], $sformatf("t6 v%0d", i), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
